// File: rtl/io_responder.sv
// io_responder: memory-mapped IO page (LED register + 8N1 UART transmitter).
// Answers bus cycles with mem_addr[22]=1 and returns read data one cycle
// after the read strobe, matching the RAM's registered read latency.
//
// Bus handshake: there is no valid/ready pair. A read is a single-cycle
// mem_rstrb pulse, answered on io_rdata after the next edge. A write is any
// cycle with mem_wmask[0]=1. Every selected cycle is accepted, so the
// processor never stalls. A UART write that arrives while busy is dropped
// and flagged in the sticky overrun bit.
module io_responder #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int NUM_LEDS    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         mem_addr,
    input  logic                mem_rstrb,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wmask,
    output logic [31:0]         io_rdata,
    output logic [NUM_LEDS-1:0] leds,
    output logic                txd
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);

    // Word offsets (mem_addr[4:2]) of the mapped registers.
    localparam logic [2:0] OFF_LEDS        = 3'd1;  // 0x04
    localparam logic [2:0] OFF_UART_DATA   = 3'd2;  // 0x08
    localparam logic [2:0] OFF_UART_STATUS = 3'd4;  // 0x10

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [NUM_LEDS-1:0]  leds_q, leds_d;
    logic [31:0]          rdata_q, rdata_d;

    logic       io_sel;
    logic [2:0] offset;
    logic       wr_en;
    logic       uart_wr;
    logic       uart_accept;
    logic       status_rd;

    // Address decode; bits outside the select line and word offset are ignored.
    assign io_sel      = mem_addr[22];
    assign offset      = mem_addr[4:2];
    assign wr_en       = io_sel & mem_wmask[0];
    assign uart_wr     = wr_en & (offset == OFF_UART_DATA);
    assign uart_accept = uart_wr & ~busy_q;
    assign status_rd   = io_sel & mem_rstrb & (offset == OFF_UART_STATUS);

    logic unused_bits;
    assign unused_bits = ^{mem_addr[31:23], mem_addr[21:5], mem_addr[1:0],
                           mem_wmask[3:1], mem_wdata[31:8]};

    // State register: UART FSM, bus-visible registers and the registered txd.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            leds_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            leds_q    <= leds_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state: each bit period is DIV cycles, counted down to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                if (uart_accept) begin
                    state_d = ST_START;
                    cnt_d   = CNT_RELOAD;
                    bit_d   = '0;
                    shift_d = mem_wdata[7:0];
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: line level is registered one edge behind the state, and
    // busy covers every non-idle state so a new byte is refused until STOP ends.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != ST_IDLE);
        unique case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Bus side: LED write, sticky overrun, and read mux sampling pre-write state.
    always_comb begin
        leds_d    = leds_q;
        overrun_d = overrun_q;
        rdata_d   = rdata_q;

        if (wr_en && (offset == OFF_LEDS)) begin
            leds_d = mem_wdata[NUM_LEDS-1:0];
        end

        // Clearing on a status read comes first so a simultaneous drop wins.
        if (status_rd) begin
            overrun_d = 1'b0;
        end
        if (uart_wr && busy_q) begin
            overrun_d = 1'b1;
        end

        if (io_sel && mem_rstrb) begin
            unique case (offset)
                OFF_LEDS:        rdata_d = 32'(leds_q);
                OFF_UART_STATUS: rdata_d = {30'b0, overrun_q, busy_q};
                default:         rdata_d = 32'b0;
            endcase
        end
    end

    assign io_rdata = rdata_q;
    assign leds     = leds_q;
    assign txd      = txd_q;

endmodule
